irq_controller: RTL and testbench

Interrupt controller that sequences the AVR core's interrupt entry and exit. It synchronises raw interrupt lines and applies a per-vector mask. It selects the highest-priority pending vector (index 0 highest) and runs a request/acknowledge/return handshake with the core. It holds one interrupt in service at a time, with no nesting, and sits between peripheral IRQ sources and the core's control unit.

---
 rtl/irq_pkg.sv | 35 +++
 rtl/irq_sync_edge.sv | 52 +++++
 rtl/irq_controller.sv | 152 +++++++++++++++
 tb/tb_irq_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and helpers for the AVR interrupt controller.
//   irq_state_e   : controller FSM state (IDLE / REQ / SERVICE), 2-bit encoded
//   IRQ_MASK_RST  : mask value after reset (every vector enabled)
//   prio_sel()    : index of the lowest set bit, which is the highest priority
// Optional build macro used by the importing modules: IRQ_EDGE_DETECT_EN
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Widest supported vector count; narrower instances zero-extend into it.
    localparam int IRQ_MAX_VECTORS = 16;

    localparam logic [IRQ_MAX_VECTORS-1:0] IRQ_MASK_RST = '1;

    // Lowest set index wins. Returns 0 when nothing is set; callers gate
    // the result with an "any pending" term.
    function automatic int unsigned prio_sel(input logic [IRQ_MAX_VECTORS-1:0] pend);
        int unsigned idx;
        idx = 0;
        for (int i = IRQ_MAX_VECTORS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchroniser for one raw interrupt line, plus an optional rising
// edge detector on the synchronised output.
// Ports:
//   clk     in   core clock
//   rst_n   in   asynchronous active-low reset
//   line_i  in   raw interrupt line, asynchronous to clk
//   rise_o  out  one-cycle pulse on a 0->1 of sync_o (only with IRQ_EDGE_DETECT_EN)
//   sync_o  out  synchronised line (second flop)
// Build macro: IRQ_EDGE_DETECT_EN adds the edge flop and rise_o.
// -----------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
`ifdef IRQ_EDGE_DETECT_EN
    output logic rise_o,
`endif
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

`ifdef IRQ_EDGE_DETECT_EN
    logic sync_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly_q <= 1'b0;
        end else begin
            sync_dly_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~sync_dly_q;
`endif

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Sequences AVR interrupt entry/exit: synchronises raw lines, applies a
// per-vector mask, picks the highest-priority pending vector (index 0 first)
// and runs the request / acknowledge / RETI handshake with the core. One
// interrupt in service at a time, no nesting, no preemption.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   irq_lines         raw interrupt requests (asynchronous)
//   irq_mask_we/wdata mask register write port (1 = enabled)
//   irq_mask          current mask register
//   gie               global interrupt enable (SREG I)
//   irq_req           request to core
//   irq_vect          vector being requested / serviced
//   irq_ack           core took irq_vect (one-cycle pulse)
//   irq_reti          core executed RETI (one-cycle pulse)
//   irq_active        an interrupt is in service
//   irq_pending       masked pending bits
// Build macro: IRQ_EDGE_DETECT_EN switches pending from level to latched
// rising-edge mode (cleared on acknowledge of that vector).
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter  int NUM_VECTORS = 4,
    localparam int NVL2        = $clog2(NUM_VECTORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_VECTORS-1:0] irq_lines,
    input  logic                   irq_mask_we,
    input  logic [NUM_VECTORS-1:0] irq_mask_wdata,
    output logic [NUM_VECTORS-1:0] irq_mask,
    input  logic                   gie,
    output logic                   irq_req,
    output logic [NVL2-1:0]        irq_vect,
    input  logic                   irq_ack,
    input  logic                   irq_reti,
    output logic                   irq_active,
    output logic [NUM_VECTORS-1:0] irq_pending
);

    logic [NUM_VECTORS-1:0] sync;
    logic [NUM_VECTORS-1:0] mask_q;
    logic [NUM_VECTORS-1:0] pend;
    logic [NVL2-1:0]        sel;
    logic                   any;
    irq_state_e             state_q, state_d;
    logic [NVL2-1:0]        vect_q, vect_d;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_VECTORS-1:0] rise;
`endif

    for (genvar g = 0; g < NUM_VECTORS; g++) begin : g_line
        irq_sync_edge u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .line_i (irq_lines[g]),
`ifdef IRQ_EDGE_DETECT_EN
            .rise_o (rise[g]),
`endif
            .sync_o (sync[g])
        );
    end

    // Mask register; the registered value feeds pend directly, so a write
    // is visible to arbitration from the cycle after its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= NUM_VECTORS'(IRQ_MASK_RST);
        end else if (irq_mask_we) begin
            mask_q <= irq_mask_wdata;
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_VECTORS-1:0] pl_q, pl_d, pl_clr;

    // Edges are latched regardless of mask. Only the acknowledged vector is
    // cleared, and an edge arriving on the clearing cycle re-arms it.
    always_comb begin
        pl_clr = '0;
        if (state_q == ST_REQ && irq_ack) begin
            pl_clr[vect_q] = 1'b1;
        end
        pl_d = (pl_q & ~pl_clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_q <= '0;
        end else begin
            pl_q <= pl_d;
        end
    end

    assign pend = pl_q & mask_q;
`else
    assign pend = sync & mask_q;
`endif

    assign any = |pend;
    assign sel = NVL2'(prio_sel(IRQ_MAX_VECTORS'(pend)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vect_q  <= '0;
        end else begin
            state_q <= state_d;
            vect_q  <= vect_d;
        end
    end

    // Arbitration happens only in IDLE; the vector is frozen through REQ and
    // SERVICE so higher-priority arrivals wait for the next IDLE.
    always_comb begin
        state_d = state_q;
        vect_d  = vect_q;
        case (state_q)
            ST_IDLE: begin
                if (gie && any) begin
                    vect_d  = sel;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acknowledge takes precedence over a simultaneous withdraw.
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                end else if (!gie || !pend[vect_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (irq_reti) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register, so reset clears them asynchronously.
    assign irq_req     = (state_q == ST_REQ);
    assign irq_active  = (state_q == ST_SERVICE);
    assign irq_vect    = vect_q;
    assign irq_mask    = mask_q;
    assign irq_pending = pend;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NV-1:0] irq_lines;
    logic          irq_mask_we;
    logic [NV-1:0] irq_mask_wdata;
    logic [NV-1:0] irq_mask;
    logic          gie;
    logic          irq_req;
    logic [1:0]    irq_vect;
    logic          irq_ack;
    logic          irq_reti;
    logic          irq_active;
    logic [NV-1:0] irq_pending;

    always #5 clk = ~clk;

    irq_controller #(.NUM_VECTORS(NV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_lines      (irq_lines),
        .irq_mask_we    (irq_mask_we),
        .irq_mask_wdata (irq_mask_wdata),
        .irq_mask       (irq_mask),
        .gie            (gie),
        .irq_req        (irq_req),
        .irq_vect       (irq_vect),
        .irq_ack        (irq_ack),
        .irq_reti       (irq_reti),
        .irq_active     (irq_active),
        .irq_pending    (irq_pending)
    );

    typedef enum {SIG_REQ, SIG_VECT, SIG_ACTIVE, SIG_MASK, SIG_PEND} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SIG_REQ:    return 32'(irq_req);
            SIG_VECT:   return 32'(irq_vect);
            SIG_ACTIVE: return 32'(irq_active);
            SIG_MASK:   return 32'(irq_mask);
            default:    return 32'(irq_pending);
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_out(input string tag, input logic r, input logic [31:0] v, input logic a);
        expect_sig({tag, "_req"},    SIG_REQ,    32'(r));
        expect_sig({tag, "_vect"},   SIG_VECT,   v);
        expect_sig({tag, "_active"}, SIG_ACTIVE, 32'(a));
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    // Advance one edge, then compare everything queued for that edge.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (irq_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_seen"}, 32'(irq_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        irq_lines      = '0;
        irq_mask_we    = 1'b0;
        irq_mask_wdata = '0;
        gie            = 1'b1;
        irq_ack        = 1'b0;
        irq_reti       = 1'b0;

        // Reset state
        step();
        expect_out("rst", 1'b0, 0, 1'b0);
        expect_sig("rst_mask", SIG_MASK, 32'hF);
        expect_sig("rst_pend", SIG_PEND, 32'h0);
        step();
        rst_n = 1'b1;

`ifndef IRQ_EDGE_DETECT_EN
        // T1: single line, 3-edge latency, ack/reti, re-request after one idle cycle
        irq_lines = 4'b0100;
        expect_out("t1_e1", 1'b0, 0, 1'b0); step();
        expect_out("t1_e2", 1'b0, 0, 1'b0);
        expect_sig("t1_pend", SIG_PEND, 32'h4); step();
        expect_out("t1_req", 1'b1, 2, 1'b0); step();
        irq_ack = 1'b1;
        expect_out("t1_ack", 1'b0, 2, 1'b1); step();
        irq_ack = 1'b0;
        expect_out("t1_svc", 1'b0, 2, 1'b1); step();
        irq_reti = 1'b1;
        expect_out("t1_reti", 1'b0, 2, 1'b0); step();
        irq_reti = 1'b0;
        expect_out("t1_rereq", 1'b1, 2, 1'b0); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_lines = '0;
        step(); step(); step();
        irq_reti = 1'b1; step(); irq_reti = 1'b0;
        expect_out("t1_quiet", 1'b0, 2, 1'b0); step();

        // T2: simultaneous lines, priority, then the lower one after reti
        irq_lines = 4'b1010;
        step(); step();
        expect_out("t2_req", 1'b1, 1, 1'b0); step();
        irq_ack = 1'b1;
        expect_out("t2_ack", 1'b0, 1, 1'b1); step();
        irq_ack = 1'b0;
        irq_lines = 4'b1000;
        step(); step();
        irq_reti = 1'b1;
        expect_out("t2_reti", 1'b0, 1, 1'b0); step();
        irq_reti = 1'b0;
        expect_out("t2_req3", 1'b1, 3, 1'b0); step();

        // T5: no preemption in SERVICE, stray pulses ignored
        irq_ack = 1'b1;
        expect_out("t5_svc", 1'b0, 3, 1'b1); step();
        irq_ack = 1'b0;
        irq_lines = 4'b1001;
        step(); step();
        expect_out("t5_nopre", 1'b0, 3, 1'b1);
        expect_sig("t5_pend", SIG_PEND, 32'h9); step();
        irq_reti = 1'b1;
        expect_out("t5_reti", 1'b0, 3, 1'b0); step();
        irq_reti = 1'b0;
        expect_out("t5_req0", 1'b1, 0, 1'b0); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_lines = '0;
        step(); step(); step();
        irq_reti = 1'b1; step(); irq_reti = 1'b0;
        irq_reti = 1'b1;
        expect_out("t5_stray_reti", 1'b0, 0, 1'b0); step();
        irq_reti = 1'b0;
        irq_ack = 1'b1;
        expect_out("t5_stray_ack", 1'b0, 0, 1'b0); step();
        irq_ack = 1'b0;

        // T3: masking the requested vector withdraws the request
        irq_lines = 4'b0100;
        step(); step();
        expect_out("t3_req", 1'b1, 2, 1'b0); step();
        irq_mask_we = 1'b1; irq_mask_wdata = 4'b1011;
        expect_sig("t3_mask", SIG_MASK, 32'hB);
        expect_sig("t3_pend", SIG_PEND, 32'h0);
        expect_sig("t3_req_hold", SIG_REQ, 32'd1); step();
        irq_mask_we = 1'b0;
        expect_out("t3_withdraw", 1'b0, 2, 1'b0);
        expect_sig("t3_pend_idle", SIG_PEND, 32'h0); step();
        irq_mask_we = 1'b1; irq_mask_wdata = 4'b1111; step();
        irq_mask_we = 1'b0;
        expect_out("t3_rereq", 1'b1, 2, 1'b0); step();

        // T4: gie falls together with ack -> ack wins; gie ignored in SERVICE
        gie = 1'b0; irq_ack = 1'b1;
        expect_out("t4_ackwins", 1'b0, 2, 1'b1); step();
        irq_ack = 1'b0;
        irq_lines = '0;
        step(); step();
        expect_out("t4_gie_ign", 1'b0, 2, 1'b1); step();
        gie = 1'b1; irq_reti = 1'b1;
        expect_out("t4_reti", 1'b0, 2, 1'b0); step();
        irq_reti = 1'b0;
        expect_out("t4_idle", 1'b0, 2, 1'b0); step();

        // T6: withdraw on gie low, and on the line dropping
        irq_lines = 4'b0001;
        step(); step();
        expect_out("t6_req", 1'b1, 0, 1'b0); step();
        gie = 1'b0;
        expect_out("t6_gie_wd", 1'b0, 0, 1'b0); step();
        gie = 1'b1;
        expect_out("t6_rereq", 1'b1, 0, 1'b0); step();
        irq_lines = '0;
        step(); step();
        expect_out("t6_line_wd", 1'b0, 0, 1'b0); step();
`else
        // Edge mode: masked pulse is latched, shows up when unmasked
        irq_mask_we = 1'b1; irq_mask_wdata = 4'b1101; step();
        irq_mask_we = 1'b0;
        irq_lines = 4'b0010; step();
        irq_lines = '0; step();
        expect_out("e_masked", 1'b0, 0, 1'b0);
        expect_sig("e_pend_masked", SIG_PEND, 32'h0); step();
        expect_sig("e_still_idle", SIG_REQ, 32'd0); step();
        irq_mask_we = 1'b1; irq_mask_wdata = 4'b1111;
        expect_sig("e_pend_unmask", SIG_PEND, 32'h2);
        expect_sig("e_req_pre", SIG_REQ, 32'd0); step();
        irq_mask_we = 1'b0;
        expect_out("e_req", 1'b1, 1, 1'b0); step();
        irq_ack = 1'b1;
        expect_out("e_ack", 1'b0, 1, 1'b1);
        expect_sig("e_pend_clr", SIG_PEND, 32'h0); step();
        irq_ack = 1'b0;
        irq_reti = 1'b1;
        expect_out("e_reti", 1'b0, 1, 1'b0); step();
        irq_reti = 1'b0;
        step();
        expect_out("e_no_rereq", 1'b0, 1, 1'b0);
        expect_sig("e_pend_none", SIG_PEND, 32'h0); step();
`endif

        // Asynchronous reset in the middle of SERVICE
        irq_lines = 4'b0100;
        wait_req("rs", 8);
        expect_sig("rs_vect", SIG_VECT, 32'd2);
        drain();
        irq_ack = 1'b1;
        expect_out("rs_svc", 1'b0, 2, 1'b1); step();
        irq_ack = 1'b0;
        irq_mask_we = 1'b1; irq_mask_wdata = 4'b0011;
        expect_sig("rs_mask_w", SIG_MASK, 32'h3); step();
        irq_mask_we = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("rs_async", 1'b0, 0, 1'b0);
        expect_sig("rs_mask", SIG_MASK, 32'hF);
        expect_sig("rs_pend", SIG_PEND, 32'h0);
        drain();
        irq_lines = '0;
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
